matrix_scalar_op_tx: RTL

- Parametrised successor of the single-mode scalar-multiply printer.
- Applies a selectable element-wise scalar operation (multiply, add, subtract) to a packed matrix of up to MAX_DIM x MAX_DIM elements.
- Streams results as decimal ASCII over the shared UART TX path, in row-major or transposed order.
- Sits between the matrix storage/selection logic and the UART transmitter, driving it through the existing value_ascii_tx printer.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_elem_alu.sv | 37 +++
 rtl/value_ascii_tx.sv | 88 ++++++++
 rtl/matrix_scalar_op_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared encodings for the matrix scalar-op printer: op codes, ASCII separators,
// controller state encoding and the default matrix dimension.
package matrix_pkg;

    localparam int MAX_DIM_DEF = 5;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    localparam logic [7:0] CHAR_SP = 8'h20;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_HDR,
        S_HWAIT,
        S_PREP,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

endpackage

// File: rtl/matrix_elem_alu.sv
// Combinational element/scalar operation unit: multiply, add, or subtract
// clamped at zero, all zero-extended to the result width.
module matrix_elem_alu
    import matrix_pkg::*;
#(
    parameter int ELEM_WIDTH   = 8,
    parameter int SCALAR_WIDTH = 4,
    parameter int RES_WIDTH    = 16
) (
    input  logic [1:0]              op,
    input  logic [ELEM_WIDTH-1:0]   elem,
    input  logic [SCALAR_WIDTH-1:0] scalar,
    output logic [RES_WIDTH-1:0]    res
);

    function automatic logic [RES_WIDTH-1:0] sat_sub(input logic [RES_WIDTH-1:0] a,
                                                     input logic [RES_WIDTH-1:0] b);
        return (a >= b) ? (a - b) : '0;
    endfunction

    logic [RES_WIDTH-1:0] elem_ext;
    logic [RES_WIDTH-1:0] scalar_ext;

    assign elem_ext   = RES_WIDTH'(elem);
    assign scalar_ext = RES_WIDTH'(scalar);

    always_comb begin
        res = '0;
        case (op)
            OP_MUL:  res = elem_ext * scalar_ext;
            OP_ADD:  res = elem_ext + scalar_ext;
            OP_SUB:  res = sat_sub(elem_ext, scalar_ext);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/value_ascii_tx.sv
// Prints one unsigned value as decimal ASCII (no leading zeros) followed by a
// tail character, one byte per UART strobe; pulses done after the tail byte.
module value_ascii_tx #(
    parameter int VALUE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   launch,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic [7:0]             tail_char,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   done
);

    // Enough decimal digits for 2^VALUE_WIDTH-1 (log10(2) ~ 0.302).
    localparam int DIGITS = (VALUE_WIDTH * 302) / 1000 + 1;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam logic [VALUE_WIDTH-1:0] TEN = VALUE_WIDTH'(10);

    typedef enum logic [2:0] {P_IDLE, P_CONV, P_SEND, P_GAP, P_DRAIN} pstate_t;

    pstate_t                pstate;
    logic [VALUE_WIDTH-1:0] work;
    logic [7:0]             tail;
    logic [CNT_W-1:0]       cnt;
    logic                   last;
    logic [3:0]             digs [DIGITS];

    always_ff @(posedge clk) begin
        if (pstate == P_CONV) digs[cnt] <= 4'(work % TEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate   <= P_IDLE;
            work     <= '0;
            tail     <= 8'h20;
            cnt      <= '0;
            last     <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (pstate)
                P_IDLE: if (launch) begin
                    work   <= value;
                    tail   <= tail_char;
                    cnt    <= '0;
                    pstate <= P_CONV;
                end
                // Digits are collected least-significant first, sent in reverse.
                P_CONV: begin
                    work <= work / TEN;
                    cnt  <= cnt + 1'b1;
                    if (work < TEN) pstate <= P_SEND;
                end
                P_SEND: if (!tx_busy) begin
                    tx_start <= 1'b1;
                    if (cnt == '0) begin
                        tx_data <= tail;
                        last    <= 1'b1;
                    end else begin
                        tx_data <= 8'h30 + {4'd0, digs[cnt - 1'b1]};
                        cnt     <= cnt - 1'b1;
                    end
                    pstate <= P_GAP;
                end
                // One idle cycle lets the UART raise busy before we sample it.
                P_GAP: pstate <= P_DRAIN;
                P_DRAIN: if (!tx_busy) begin
                    if (last) begin
                        last   <= 1'b0;
                        done   <= 1'b1;
                        pstate <= P_IDLE;
                    end else begin
                        pstate <= P_SEND;
                    end
                end
                default: pstate <= P_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/matrix_scalar_op_tx.sv
// Applies mul/add/sub-saturate of a scalar to each matrix element and prints the
// results row-major or transposed. Optional "rows cols" header: MATRIX_OP_HEADER_EN.
module matrix_scalar_op_tx
    import matrix_pkg::*;
#(
    parameter int ELEM_WIDTH   = 8,
    parameter int MAX_DIM      = MAX_DIM_DEF,
    parameter int SCALAR_WIDTH = 4,
    parameter int RES_WIDTH    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [1:0]                            op,
    input  logic                                  transpose,
    input  logic [3:0]                            m,
    input  logic [3:0]                            n,
    input  logic [SCALAR_WIDTH-1:0]               scalar,
    input  logic [ELEM_WIDTH*MAX_DIM*MAX_DIM-1:0] in_matrix,
    input  logic                                  tx_busy,
    output logic                                  tx_start,
    output logic [7:0]                            tx_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    state_t                  state;
    logic [1:0]              op_q;
    logic                    tr_q;
    logic [3:0]              m_q;
    logic [3:0]              n_q;
    logic [SCALAR_WIDTH-1:0] scalar_q;
    logic [3:0]              outer;
    logic [3:0]              inner;
    logic [RES_WIDTH-1:0]    value_buf;
    logic [7:0]              tail_char;
    logic                    launch;
    logic                    abort_q;
    logic                    prn_done;
`ifdef MATRIX_OP_HEADER_EN
    logic                    hdr_second;
`endif

    logic [8:0]              idx;
    logic [ELEM_WIDTH-1:0]   elem;
    logic [RES_WIDTH-1:0]    alu_res;
    logic [3:0]              line_len;
    logic [3:0]              num_lines;
    logic                    last_in_line;
    logic                    last_line;
    logic                    bad_cfg;

    // Transposed output walks columns: a line is one column of m values.
    assign line_len     = tr_q ? m_q : n_q;
    assign num_lines    = tr_q ? n_q : m_q;
    assign last_in_line = (inner == line_len - 4'd1);
    assign last_line    = (outer == num_lines - 4'd1);
    assign bad_cfg      = (m_q == 4'd0) || (n_q == 4'd0) || (m_q > 4'(MAX_DIM)) ||
                          (n_q > 4'(MAX_DIM)) || (op_q == 2'b11);

    always_comb begin
        if (tr_q) idx = {5'd0, inner} * {5'd0, n_q} + {5'd0, outer};
        else      idx = {5'd0, outer} * {5'd0, n_q} + {5'd0, inner};
    end

    always_comb begin
        elem = '0;
        for (int k = 0; k < MAX_DIM * MAX_DIM; k++) begin
            if (idx == 9'(k)) elem = in_matrix[k*ELEM_WIDTH +: ELEM_WIDTH];
        end
    end

    matrix_elem_alu #(
        .ELEM_WIDTH  (ELEM_WIDTH),
        .SCALAR_WIDTH(SCALAR_WIDTH),
        .RES_WIDTH   (RES_WIDTH)
    ) u_alu (
        .op    (op_q),
        .elem  (elem),
        .scalar(scalar_q),
        .res   (alu_res)
    );

    value_ascii_tx #(
        .VALUE_WIDTH(RES_WIDTH)
    ) u_printer (
        .clk      (clk),
        .rst_n    (rst_n),
        .launch   (launch),
        .value    (value_buf),
        .tail_char(tail_char),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .done     (prn_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            launch    <= 1'b0;
            abort_q   <= 1'b0;
            op_q      <= 2'b00;
            tr_q      <= 1'b0;
            m_q       <= 4'd0;
            n_q       <= 4'd0;
            scalar_q  <= '0;
            outer     <= 4'd0;
            inner     <= 4'd0;
            value_buf <= '0;
            tail_char <= CHAR_SP;
`ifdef MATRIX_OP_HEADER_EN
            hdr_second <= 1'b0;
`endif
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            launch <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    op_q     <= op;
                    tr_q     <= transpose;
                    m_q      <= m;
                    n_q      <= n;
                    scalar_q <= scalar;
                    abort_q  <= 1'b0;
                    busy     <= 1'b1;
                    state    <= S_CHECK;
                end
                S_CHECK: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (bad_cfg) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        outer <= 4'd0;
                        inner <= 4'd0;
`ifdef MATRIX_OP_HEADER_EN
                        hdr_second <= 1'b0;
                        state      <= S_HDR;
`else
                        state      <= S_PREP;
`endif
                    end
                end
`ifdef MATRIX_OP_HEADER_EN
                S_HDR: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        value_buf <= RES_WIDTH'(hdr_second ? line_len : num_lines);
                        tail_char <= hdr_second ? CHAR_LF : CHAR_SP;
                        launch    <= 1'b1;
                        state     <= S_HWAIT;
                    end
                end
                S_HWAIT: begin
                    if (abort) abort_q <= 1'b1;
                    if (prn_done) begin
                        if (abort || abort_q) begin
                            busy    <= 1'b0;
                            abort_q <= 1'b0;
                            state   <= S_IDLE;
                        end else if (hdr_second) begin
                            state <= S_PREP;
                        end else begin
                            hdr_second <= 1'b1;
                            state      <= S_HDR;
                        end
                    end
                end
`endif
                S_PREP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        value_buf <= alu_res;
                        tail_char <= last_in_line ? CHAR_LF : CHAR_SP;
                        launch    <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                // An abort here is remembered so the number in flight finishes intact.
                S_WAIT: begin
                    if (abort) abort_q <= 1'b1;
                    if (prn_done) begin
                        if (abort || abort_q) begin
                            busy    <= 1'b0;
                            abort_q <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (last_in_line) begin
                        inner <= 4'd0;
                        if (last_line) begin
                            state <= S_FINISH;
                        end else begin
                            outer <= outer + 4'd1;
                            state <= S_PREP;
                        end
                    end else begin
                        inner <= inner + 4'd1;
                        state <= S_PREP;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    done  <= !abort;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
